// File: rtl/mmu_xlate_ctrl.sv
// Translation front-end: arbitrates IF/MEM translation requests onto a single TLB port,
// decodes fixed segments locally and sequences mapped accesses through the TLB.
module mmu_xlate_ctrl #(
  parameter int WITH_TLB = 1,
  parameter int PFN_W    = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             user_mode,
  input  logic             kseg0_uncached,
  input  logic             flush,
  input  logic             i_req,
  input  logic [31:0]      i_vaddr,
  output logic             i_gnt,
  output logic             i_resp_valid,
  input  logic             d_req,
  input  logic [31:0]      d_vaddr,
  input  logic             d_we,
  output logic             d_gnt,
  output logic             d_resp_valid,
  output logic [31:0]      resp_paddr,
  output logic             resp_uncached,
  output logic [2:0]       resp_exc,
  output logic             tlb_req,
  output logic [31:0]      tlb_vaddr,
  input  logic             tlb_ack,
  input  logic             tlb_hit,
  input  logic             tlb_v,
  input  logic             tlb_d,
  input  logic [PFN_W-1:0] tlb_pfn,
  input  logic [2:0]       tlb_c
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RESP   = 2'd1,
    S_LOOKUP = 2'd2,
    S_ABORT  = 2'd3
  } state_t;

  localparam logic [2:0] EXC_NONE = 3'd0;
  localparam logic [2:0] EXC_ADEL = 3'd1;
  localparam logic [2:0] EXC_REFL = 3'd2;
  localparam logic [2:0] EXC_INV  = 3'd3;
  localparam logic [2:0] EXC_MOD  = 3'd4;

  state_t      r_state;
  logic        r_rr_last;   // 1 = data granted last
  logic        r_sel;       // requester of the transaction in flight, 1 = data
  logic        r_we;
  logic [11:0] r_va_lo;
  logic [31:0] r_pend_paddr;
  logic        r_pend_unc;
  logic [2:0]  r_pend_exc;
  logic        r_i_gnt, r_d_gnt, r_i_resp, r_d_resp, r_unc, r_tlb_req;
  logic [31:0] r_paddr, r_tlb_vaddr;
  logic [2:0]  r_exc;

  logic        w_pick_d, w_grant, w_mapped, w_unc, w_tlb_unc;
  logic [31:0] w_vaddr, w_paddr, w_tlb_paddr;
  logic [2:0]  w_exc, w_tlb_exc;

  // Round-robin pick: on a tie the side not granted last wins.
  assign w_pick_d = d_req & (~i_req | ~r_rr_last);
  assign w_grant  = (r_state == S_IDLE) & ~flush & (i_req | d_req);
  assign w_vaddr  = w_pick_d ? d_vaddr : i_vaddr;

  // Segment decode of the candidate request.
  always_comb begin
    w_mapped = 1'b0;
    w_paddr  = 32'd0;
    w_unc    = 1'b0;
    w_exc    = EXC_NONE;
    if (user_mode & w_vaddr[31]) begin
      w_exc = EXC_ADEL;
    end else if (w_vaddr[31:29] == 3'b100) begin
      w_paddr = {3'b000, w_vaddr[28:0]};
      w_unc   = kseg0_uncached;
    end else if (w_vaddr[31:29] == 3'b101) begin
      w_paddr = {3'b000, w_vaddr[28:0]};
      w_unc   = 1'b1;
    end else if (WITH_TLB != 0) begin
      w_mapped = 1'b1;
    end else begin
      w_paddr = w_vaddr;
    end
  end

  // TLB result classification for the latched access.
  always_comb begin
    w_tlb_paddr = 32'd0;
    w_tlb_unc   = 1'b0;
    w_tlb_exc   = EXC_NONE;
    if (!tlb_hit) begin
      w_tlb_exc = EXC_REFL;
    end else if (!tlb_v) begin
      w_tlb_exc = EXC_INV;
    end else if (r_we & ~tlb_d) begin
      w_tlb_exc = EXC_MOD;
    end else begin
      w_tlb_paddr = 32'({tlb_pfn, r_va_lo});
      w_tlb_unc   = (tlb_c == 3'b010);
    end
  end

  // Control FSM; pulses and response fields default low every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_rr_last    <= 1'b1;
      r_sel        <= 1'b0;
      r_we         <= 1'b0;
      r_va_lo      <= 12'd0;
      r_pend_paddr <= 32'd0;
      r_pend_unc   <= 1'b0;
      r_pend_exc   <= EXC_NONE;
      r_i_gnt      <= 1'b0;
      r_d_gnt      <= 1'b0;
      r_i_resp     <= 1'b0;
      r_d_resp     <= 1'b0;
      r_paddr      <= 32'd0;
      r_unc        <= 1'b0;
      r_exc        <= EXC_NONE;
      r_tlb_req    <= 1'b0;
      r_tlb_vaddr  <= 32'd0;
    end else begin
      r_i_gnt  <= 1'b0;
      r_d_gnt  <= 1'b0;
      r_i_resp <= 1'b0;
      r_d_resp <= 1'b0;
      r_paddr  <= 32'd0;
      r_unc    <= 1'b0;
      r_exc    <= EXC_NONE;
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_i_gnt      <= ~w_pick_d;
            r_d_gnt      <= w_pick_d;
            r_sel        <= w_pick_d;
            r_rr_last    <= w_pick_d;
            r_we         <= w_pick_d & d_we;
            r_va_lo      <= w_vaddr[11:0];
            r_pend_paddr <= w_paddr;
            r_pend_unc   <= w_unc;
            r_pend_exc   <= w_exc;
            if (w_mapped) begin
              r_tlb_vaddr <= w_vaddr;
              r_state     <= S_LOOKUP;
            end else begin
              r_state <= S_RESP;
            end
          end
        end
        S_RESP: begin
          if (!flush) begin
            r_i_resp <= ~r_sel;
            r_d_resp <= r_sel;
            r_paddr  <= r_pend_paddr;
            r_unc    <= r_pend_unc;
            r_exc    <= r_pend_exc;
          end
          r_state <= S_IDLE;
        end
        S_LOOKUP: begin
          if (!r_tlb_req) begin
            // A flush before the lookup is issued leaves nothing outstanding at the TLB.
            if (flush) r_state <= S_IDLE;
            else       r_tlb_req <= 1'b1;
          end else if (tlb_ack) begin
            r_tlb_req <= 1'b0;
            r_state   <= S_IDLE;
            if (!flush) begin
              r_i_resp <= ~r_sel;
              r_d_resp <= r_sel;
              r_paddr  <= w_tlb_paddr;
              r_unc    <= w_tlb_unc;
              r_exc    <= w_tlb_exc;
            end
          end else if (flush) begin
            r_state <= S_ABORT;
          end
        end
        S_ABORT: begin
          if (tlb_ack) begin
            r_tlb_req <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: begin
          r_tlb_req <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  assign i_gnt         = r_i_gnt;
  assign d_gnt         = r_d_gnt;
  assign i_resp_valid  = r_i_resp;
  assign d_resp_valid  = r_d_resp;
  assign resp_paddr    = r_paddr;
  assign resp_uncached = r_unc;
  assign resp_exc      = r_exc;
  assign tlb_req       = r_tlb_req;
  assign tlb_vaddr     = r_tlb_vaddr;

endmodule

// File: tb/tb_mmu_xlate_ctrl.sv
// Directed bench for mmu_xlate_ctrl: vector table of single translations plus
// hand-written arbitration and flush sequences.
module tb_mmu_xlate_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        user_mode, kseg0_uncached, flush;
  logic        i_req, d_req, d_we;
  logic [31:0] i_vaddr, d_vaddr;
  logic        i_gnt, d_gnt, i_resp_valid, d_resp_valid;
  logic [31:0] resp_paddr, tlb_vaddr;
  logic        resp_uncached, tlb_req;
  logic [2:0]  resp_exc;
  logic        tlb_ack, tlb_hit, tlb_v, tlb_d;
  logic [19:0] tlb_pfn;
  logic [2:0]  tlb_c;

  int total = 0;
  int bad   = 0;

  mmu_xlate_ctrl #(.WITH_TLB(1), .PFN_W(20)) dut (
    .clk(clk), .rst(rst), .user_mode(user_mode), .kseg0_uncached(kseg0_uncached),
    .flush(flush), .i_req(i_req), .i_vaddr(i_vaddr), .i_gnt(i_gnt),
    .i_resp_valid(i_resp_valid), .d_req(d_req), .d_vaddr(d_vaddr), .d_we(d_we),
    .d_gnt(d_gnt), .d_resp_valid(d_resp_valid), .resp_paddr(resp_paddr),
    .resp_uncached(resp_uncached), .resp_exc(resp_exc), .tlb_req(tlb_req),
    .tlb_vaddr(tlb_vaddr), .tlb_ack(tlb_ack), .tlb_hit(tlb_hit), .tlb_v(tlb_v),
    .tlb_d(tlb_d), .tlb_pfn(tlb_pfn), .tlb_c(tlb_c)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_d;
    logic [31:0] va;
    logic        we;
    logic        um;
    logic        k0u;
    logic        mapped;
    int          dly;
    logic        hit, v, d;
    logic [19:0] pfn;
    logic [2:0]  c;
    logic [31:0] e_pa;
    logic        e_unc;
    logic [2:0]  e_exc;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; flush = 1'b0;
    tlb_ack = 1'b0; tlb_hit = 1'b0; tlb_v = 1'b0; tlb_d = 1'b0;
    tlb_pfn = 20'd0; tlb_c = 3'd0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    logic got;
    @(negedge clk);
    i_req = ~v.is_d; d_req = v.is_d;
    i_vaddr = v.va; d_vaddr = v.va; d_we = v.we;
    user_mode = v.um; kseg0_uncached = v.k0u;
    got = 1'b0;
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge clk);
      if (v.is_d ? d_gnt : i_gnt) got = 1'b1;
    end
    chk($sformatf("v%0d gnt", idx), {31'd0, got}, 32'd1);
    // change mode inputs after grant: the design must use the latched copies
    i_req = 1'b0; d_req = 1'b0; d_we = ~v.we;
    user_mode = ~v.um; kseg0_uncached = ~v.k0u;
    if (v.mapped) begin
      @(negedge clk);
      chk($sformatf("v%0d tlb_req", idx), {31'd0, tlb_req}, 32'd1);
      chk($sformatf("v%0d tlb_vaddr", idx), tlb_vaddr, v.va);
      repeat (v.dly) @(negedge clk);
      tlb_ack = 1'b1; tlb_hit = v.hit; tlb_v = v.v; tlb_d = v.d;
      tlb_pfn = v.pfn; tlb_c = v.c;
      @(negedge clk);
      tlb_ack = 1'b0; tlb_hit = 1'b0; tlb_v = 1'b0; tlb_d = 1'b0;
      tlb_pfn = 20'd0; tlb_c = 3'd0;
    end else begin
      @(negedge clk);
      chk($sformatf("v%0d no tlb_req", idx), {31'd0, tlb_req}, 32'd0);
    end
    chk($sformatf("v%0d i_resp", idx), {31'd0, i_resp_valid}, {31'd0, ~v.is_d});
    chk($sformatf("v%0d d_resp", idx), {31'd0, d_resp_valid}, {31'd0, v.is_d});
    chk($sformatf("v%0d paddr", idx), resp_paddr, v.e_pa);
    chk($sformatf("v%0d unc", idx), {31'd0, resp_uncached}, {31'd0, v.e_unc});
    chk($sformatf("v%0d exc", idx), {29'd0, resp_exc}, {29'd0, v.e_exc});
    @(negedge clk);
    chk($sformatf("v%0d resp drop", idx), {30'd0, i_resp_valid, d_resp_valid}, 32'd0);
    chk($sformatf("v%0d paddr drop", idx), resp_paddr, 32'd0);
  endtask

  int          order[4];
  int          ngr;
  logic        seen;

  initial begin
    //          is_d  va            we    um    k0u   map  dly hit   v     d     pfn        c       e_pa          unc   exc
    vecs[0]  = '{1'b0, 32'hBFC00000, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 20'h00000, 3'd0, 32'h1FC00000, 1'b1, 3'd0};
    vecs[1]  = '{1'b1, 32'h80001000, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 20'h00000, 3'd0, 32'h00001000, 1'b1, 3'd0};
    vecs[2]  = '{1'b1, 32'h80001000, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 20'h00000, 3'd0, 32'h00001000, 1'b0, 3'd0};
    vecs[3]  = '{1'b1, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 20'h00000, 3'd0, 32'h00000000, 1'b0, 3'd1};
    vecs[4]  = '{1'b0, 32'hBFC00000, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 20'h00000, 3'd0, 32'h00000000, 1'b0, 3'd1};
    vecs[5]  = '{1'b1, 32'h00402ABC, 1'b1, 1'b0, 1'b0, 1'b1, 2, 1'b1, 1'b1, 1'b0, 20'h12345, 3'd3, 32'h00000000, 1'b0, 3'd4};
    vecs[6]  = '{1'b1, 32'h00402ABC, 1'b1, 1'b0, 1'b0, 1'b1, 2, 1'b1, 1'b1, 1'b1, 20'h12345, 3'd3, 32'h12345ABC, 1'b0, 3'd0};
    vecs[7]  = '{1'b1, 32'h00402ABC, 1'b1, 1'b0, 1'b0, 1'b1, 2, 1'b0, 1'b1, 1'b1, 20'h12345, 3'd2, 32'h00000000, 1'b0, 3'd2};
    vecs[8]  = '{1'b1, 32'h00402ABC, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b1, 1'b0, 1'b1, 20'h12345, 3'd2, 32'h00000000, 1'b0, 3'd3};
    vecs[9]  = '{1'b1, 32'h00402ABC, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b1, 1'b1, 1'b0, 20'hABCDE, 3'd2, 32'hABCDEABC, 1'b1, 3'd0};
    vecs[10] = '{1'b0, 32'hC0000010, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b1, 1'b1, 1'b0, 20'h00077, 3'd3, 32'h00077010, 1'b0, 3'd0};
    vecs[11] = '{1'b0, 32'hE0001FFF, 1'b0, 1'b0, 1'b1, 1'b1, 3, 1'b1, 1'b1, 1'b0, 20'hFFFFF, 3'd3, 32'hFFFFFFFF, 1'b0, 3'd0};
    vecs[12] = '{1'b1, 32'h7FFFF123, 1'b0, 1'b1, 1'b0, 1'b1, 1, 1'b1, 1'b1, 1'b1, 20'h00001, 3'd3, 32'h00001123, 1'b0, 3'd0};
    vecs[13] = '{1'b1, 32'hA0000004, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 20'h00000, 3'd0, 32'h00000004, 1'b1, 3'd0};

    rst = 1'b1; user_mode = 1'b0; kseg0_uncached = 1'b0;
    i_vaddr = 32'd0; d_vaddr = 32'd0;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset gnt/resp", {28'd0, i_gnt, d_gnt, i_resp_valid, d_resp_valid}, 32'd0);
    chk("reset tlb_req", {31'd0, tlb_req}, 32'd0);
    chk("reset tlb_vaddr", tlb_vaddr, 32'd0);
    chk("reset resp", {resp_paddr[28:0], resp_exc} | {31'd0, resp_uncached}, 32'd0);

    for (int i = 0; i < 14; i++) run_vec(i, vecs[i]);

    // Round-robin under continuous requests from both sides, starting fresh from reset
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    user_mode = 1'b0; i_vaddr = 32'hA0000000; d_vaddr = 32'hA0000100;
    i_req = 1'b1; d_req = 1'b1;
    ngr = 0;
    for (int k = 0; k < 20 && ngr < 4; k++) begin
      @(negedge clk);
      if (i_gnt & d_gnt) chk("rr double grant", 32'd1, 32'd0);
      if (i_gnt) begin order[ngr] = 0; ngr++; end
      else if (d_gnt) begin order[ngr] = 1; ngr++; end
    end
    i_req = 1'b0; d_req = 1'b0;
    chk("rr grant count", ngr, 32'd4);
    for (int k = 0; k < 4; k++) if (k < ngr) chk($sformatf("rr order %0d", k), order[k], k % 2);
    repeat (3) @(negedge clk);

    // Flush in IDLE blocks the grant for that cycle
    d_vaddr = 32'hA0000000; d_we = 1'b0; d_req = 1'b1; flush = 1'b1;
    @(negedge clk);
    chk("flush idle no gnt", {31'd0, d_gnt}, 32'd0);
    flush = 1'b0;
    @(negedge clk);
    chk("flush idle later gnt", {31'd0, d_gnt}, 32'd1);
    d_req = 1'b0;
    @(negedge clk);
    chk("flush idle resp", {31'd0, d_resp_valid}, 32'd1);

    // Flush in RESP drops the response
    @(negedge clk);
    i_vaddr = 32'hBFC00000; i_req = 1'b1;
    @(negedge clk);
    chk("flush resp gnt", {31'd0, i_gnt}, 32'd1);
    i_req = 1'b0; flush = 1'b1;
    @(negedge clk);
    chk("flush resp suppressed", {31'd0, i_resp_valid}, 32'd0);
    flush = 1'b0;
    @(negedge clk);
    chk("flush resp stays low", {30'd0, i_resp_valid, d_resp_valid}, 32'd0);

    // Flush during LOOKUP: lookup held until ack, result discarded, next grant only after
    d_vaddr = 32'h00402ABC; d_req = 1'b1;
    @(negedge clk);
    chk("abort gnt", {31'd0, d_gnt}, 32'd1);
    d_req = 1'b0;
    @(negedge clk);
    chk("abort tlb_req up", {31'd0, tlb_req}, 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; i_vaddr = 32'hBFC00000; i_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      chk($sformatf("abort hold tlb_req %0d", k), {31'd0, tlb_req}, 32'd1);
      chk($sformatf("abort quiet %0d", k), {29'd0, i_gnt, i_resp_valid, d_resp_valid}, 32'd0);
    end
    tlb_ack = 1'b1; tlb_hit = 1'b1; tlb_v = 1'b1; tlb_d = 1'b1; tlb_pfn = 20'h55555;
    @(negedge clk);
    idle_inputs(); i_req = 1'b1;
    chk("abort tlb_req drop", {31'd0, tlb_req}, 32'd0);
    chk("abort result discarded", {29'd0, i_gnt, i_resp_valid, d_resp_valid}, 32'd0);
    seen = 1'b0;
    for (int k = 0; k < 6 && !seen; k++) begin
      @(negedge clk);
      if (d_resp_valid) chk("abort stray d_resp", 32'd1, 32'd0);
      if (i_gnt) seen = 1'b1;
    end
    chk("abort next gnt", {31'd0, seen}, 32'd1);
    i_req = 1'b0;
    @(negedge clk);
    chk("abort next resp", {31'd0, i_resp_valid}, 32'd1);
    chk("abort next paddr", resp_paddr, 32'h1FC00000);

    // Reset during a lookup drops tlb_req immediately
    @(negedge clk);
    d_vaddr = 32'h00001000; d_req = 1'b1;
    repeat (2) @(negedge clk);
    d_req = 1'b0;
    chk("rst-lookup tlb_req up", {31'd0, tlb_req}, 32'd1);
    #1 rst = 1'b1;
    #1 chk("rst-lookup tlb_req async drop", {31'd0, tlb_req}, 32'd0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
